// File: rtl/uart_tx_frame_engine.sv
// -----------------------------------------------------------------------------
// uart_tx_frame_engine
//
// Serializes one parallel word into an asynchronous serial frame, least
// significant data bit first:
//   start (0) | DATA_WIDTH data bits | optional parity | STOP_BITS stop (1)
// Bit timing is taken from an external one-CLK-wide baud strobe (Bit_Tick).
//
// Handshake: a word is accepted on a rising CLK edge where Data_Valid=1 and
// Busy=0. Busy is high from the cycle after acceptance until the edge that
// ends the last stop bit; while Busy=1 every input except Bit_Tick is ignored
// and nothing is queued. Frame_Done pulses for one cycle on that final edge.
//
// Parameters:
//   DATA_WIDTH  data bits per frame (5..9)
//   STOP_BITS   stop bits per frame (1 or 2)
//
// Ports:
//   CLK           in   system clock, rising edge
//   RST           in   asynchronous active-high reset
//   P_Data        in   word to transmit
//   Data_Valid    in   transmit request
//   PAR_EN        in   1 = append parity bit (sampled at acceptance)
//   PAR_TYP       in   0 = even, 1 = odd parity (sampled at acceptance)
//   Bit_Tick      in   baud strobe, one pulse per bit period
//   TX_Out        out  registered serial line, idles high
//   Busy          out  frame in progress
//   Frame_Done    out  one-cycle pulse when the engine returns to IDLE
//   o_dbg_state   out  current FSM state encoding
// -----------------------------------------------------------------------------
module uart_tx_frame_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_Data,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  Bit_Tick,
  output logic                  TX_Out,
  output logic                  Busy,
  output logic                  Frame_Done,
  output logic [2:0]            o_dbg_state
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT  = CW'(DATA_WIDTH - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARMED  = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
    S_PARITY = 3'd4,
    S_STOP   = 3'd5
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_par_en;
  logic                  r_parity;
  logic [CW-1:0]         r_bit_cnt;
  logic                  r_stop_cnt;
  logic [CW-1:0]         w_next_idx;

  assign w_next_idx  = r_bit_cnt + 1'b1;
  assign o_dbg_state = r_state;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_data     <= '0;
      r_par_en   <= 1'b0;
      r_parity   <= 1'b0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      TX_Out     <= 1'b1;
      Busy       <= 1'b0;
      Frame_Done <= 1'b0;
    end else begin
      Frame_Done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          TX_Out <= 1'b1;
          Busy   <= 1'b0;
          // Bit_Tick is deliberately ignored here: a tick on the accepting
          // edge must not start the frame, so the start bit waits in ARMED.
          if (Data_Valid) begin
            r_data   <= P_Data;
            r_par_en <= PAR_EN;
            // Even parity is the XOR of the data; odd flips it.
            r_parity <= (^P_Data) ^ PAR_TYP;
            Busy     <= 1'b1;
            r_state  <= S_ARMED;
          end
        end

        S_ARMED: begin
          if (Bit_Tick) begin
            TX_Out  <= 1'b0;
            r_state <= S_START;
          end
        end

        S_START: begin
          if (Bit_Tick) begin
            TX_Out    <= r_data[0];
            r_bit_cnt <= '0;
            r_state   <= S_DATA;
          end
        end

        S_DATA: begin
          if (Bit_Tick) begin
            if (r_bit_cnt < LAST_BIT) begin
              r_bit_cnt <= w_next_idx;
              TX_Out    <= r_data[w_next_idx];
            end else if (r_par_en) begin
              TX_Out  <= r_parity;
              r_state <= S_PARITY;
            end else begin
              TX_Out     <= 1'b1;
              r_stop_cnt <= 1'b0;
              r_state    <= S_STOP;
            end
          end
        end

        S_PARITY: begin
          if (Bit_Tick) begin
            TX_Out     <= 1'b1;
            r_stop_cnt <= 1'b0;
            r_state    <= S_STOP;
          end
        end

        S_STOP: begin
          // Each tick here ends one stop bit; the tick that ends the last
          // one releases Busy, so the next word can be taken one edge later.
          if (Bit_Tick) begin
            if (r_stop_cnt == STOP_LAST) begin
              r_stop_cnt <= 1'b0;
              Busy       <= 1'b0;
              Frame_Done <= 1'b1;
              r_state    <= S_IDLE;
            end else begin
              r_stop_cnt <= r_stop_cnt + 1'b1;
            end
          end
        end

        default: begin
          TX_Out  <= 1'b1;
          Busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame_engine.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_frame_engine
//
// Three engine instances share one clock and reset:
//   inst0: DATA_WIDTH=8, STOP_BITS=1
//   inst1: DATA_WIDTH=8, STOP_BITS=2
//   inst2: DATA_WIDTH=5, STOP_BITS=1
// Each instance has a frame-level reference model: on acceptance it builds
// the expected bit list and pushes it to exp_q, then counts ticks to know
// when the line should carry which bit and when Busy/Frame_Done change.
// A separate monitor rebuilds each transmitted frame from the line and pops
// exp_q on Frame_Done.
// -----------------------------------------------------------------------------
module tb_uart_tx_frame_engine;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- per-instance stimulus and observation ----------------
  logic [8:0] p_data [3];
  logic       dv     [3];
  logic       pen    [3];
  logic       ptyp   [3];
  logic       tick   [3];
  logic       tx     [3];
  logic       busy   [3];
  logic       fd     [3];
  logic [2:0] st     [3];
  int         tick_mode [3];  // 0 = no ticks, n>0 = every n CLKs, <0 = random

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int k,
                       input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s inst%0d got %0h expected %0h at %0t", name, k, got, exp, $time);
    end
  endtask

  // ---------------- instances, models, monitors ----------------
  for (genvar k = 0; k < 3; k++) begin : g_inst
    localparam int DW = (k == 2) ? 5 : 8;
    localparam int SB = (k == 1) ? 2 : 1;

    uart_tx_frame_engine #(.DATA_WIDTH(DW), .STOP_BITS(SB)) u_dut (
      .CLK         (clk),
      .RST         (rst),
      .P_Data      (p_data[k][DW-1:0]),
      .Data_Valid  (dv[k]),
      .PAR_EN      (pen[k]),
      .PAR_TYP     (ptyp[k]),
      .Bit_Tick    (tick[k]),
      .TX_Out      (tx[k]),
      .Busy        (busy[k]),
      .Frame_Done  (fd[k]),
      .o_dbg_state (st[k])
    );

    // expected frames: [20:16] length in bits, [15:0] bits, bit 0 sent first
    logic [20:0] exp_q[$];

    // reference model state
    logic        m_busy = 1'b0;
    logic        m_fd   = 1'b0;
    logic        m_line = 1'b1;
    int          m_cnt  = 0;
    int          m_n    = 0;
    logic [15:0] m_bits = '1;

    // monitor state
    logic        mon_tb   = 1'b0;
    int          mon_len  = 0;
    logic [15:0] mon_bits = '1;
    logic [20:0] e;
    int          tcnt = 0;

    // baud strobe generator
    initial begin
      forever begin
        @(negedge clk);
        if (tick_mode[k] == 0) tick[k] = 1'b0;
        else if (tick_mode[k] < 0) tick[k] = ($urandom_range(0, 2) == 0);
        else if (tcnt >= tick_mode[k] - 1) begin
          tick[k] = 1'b1;
          tcnt = 0;
        end else begin
          tick[k] = 1'b0;
          tcnt++;
        end
      end
    end

    // reference model: frame = start, data LSB first, parity?, stops.
    // Tick j after acceptance (j=1..N) starts bit j-1; tick N+1 ends frame.
    initial begin
      forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
          m_busy = 1'b0;
          m_fd   = 1'b0;
          m_cnt  = 0;
          m_line = 1'b1;
          exp_q.delete();
        end else begin
          m_fd = 1'b0;
          if (!m_busy) begin
            if (dv[k]) begin
              m_bits    = '1;
              m_bits[0] = 1'b0;
              for (int i = 0; i < DW; i++) m_bits[1 + i] = p_data[k][i];
              m_n = 1 + DW + SB;
              if (pen[k]) begin
                m_bits[1 + DW] = (^p_data[k][DW-1:0]) ^ ptyp[k];
                m_n++;
              end
              m_busy = 1'b1;
              m_cnt  = 0;
              exp_q.push_back({5'(m_n), m_bits});
            end
          end else if (tick[k]) begin
            m_cnt++;
            if (m_cnt == m_n + 1) begin
              m_busy = 1'b0;
              m_fd   = 1'b1;
            end
          end
          m_line = (m_busy && m_cnt >= 1) ? m_bits[m_cnt - 1] : 1'b1;
        end
      end
    end

    // cycle checker against the model
    initial begin
      forever begin
        @(negedge clk);
        if (!rst) begin
          check("busy",       k, 32'(busy[k]), 32'(m_busy));
          check("tx_line",    k, 32'(tx[k]),   32'(m_line));
          check("frame_done", k, 32'(fd[k]),   32'(m_fd));
        end
      end
    end

    // monitor: note ticks that land while Busy is high
    initial begin
      forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
          mon_tb   = 1'b0;
          mon_len  = 0;
          mon_bits = '1;
        end else begin
          mon_tb = tick[k] && busy[k];
        end
      end
    end

    // monitor: collect line bits, score a frame on Frame_Done
    initial begin
      forever begin
        @(negedge clk);
        if (!rst && mon_tb) begin
          if (fd[k]) begin
            if (exp_q.size() == 0) begin
              check("sb_unexpected_frame", k, 32'(mon_len), 32'(0));
            end else begin
              e = exp_q.pop_front();
              check("frame_len",  k, 32'(mon_len),  32'(e[20:16]));
              check("frame_bits", k, 32'(mon_bits), 32'(e[15:0]));
            end
            mon_len  = 0;
            mon_bits = '1;
          end else begin
            if (mon_len < 16) mon_bits[mon_len] = tx[k];
            mon_len++;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_done(input int k);
    int n;
    n = 0;
    while (!fd[k] && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", k, 32'(fd[k]), 32'(1));
  endtask

  task automatic send(input int k, input logic [8:0] d, input logic pe, input logic pt);
    int n;
    @(negedge clk);
    p_data[k] = d;
    pen[k]    = pe;
    ptyp[k]   = pt;
    dv[k]     = 1'b1;
    n = 0;
    @(negedge clk);
    while (!busy[k] && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("accept", k, 32'(busy[k]), 32'(1));
    dv[k]     = 1'b0;
    // inputs are don't-care once the word is latched
    p_data[k] = 9'($urandom);
    pen[k]    = 1'($urandom);
    ptyp[k]   = 1'($urandom);
  endtask

  task automatic async_reset_check();
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("rst_tx",    k, 32'(tx[k]),   32'(1));
      check("rst_busy",  k, 32'(busy[k]), 32'(0));
      check("rst_fd",    k, 32'(fd[k]),   32'(0));
      check("rst_state", k, 32'(st[k]),   32'(0));
    end
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #900000;
    $display("FAIL watchdog simulation did not finish at %0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    int k;
    int n;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      p_data[i] = '0; dv[i] = 1'b0; pen[i] = 1'b0; ptyp[i] = 1'b0;
      tick[i] = 1'b0; tick_mode[i] = 2;
    end
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;

    // idle line with no requests, then asynchronous reset mid-cycle
    repeat (20) @(negedge clk);
    @(posedge clk);
    async_reset_check();

    // even parity 0xA5, tick every 4 CLKs
    tick_mode[0] = 4;
    send(0, 9'h0A5, 1'b1, 1'b0);
    wait_done(0);

    // odd parity and no parity on 0x0F
    send(0, 9'h00F, 1'b1, 1'b1);
    wait_done(0);
    send(0, 9'h00F, 1'b0, 1'b0);
    wait_done(0);

    // two stop bits, Data_Valid held across back-to-back frames
    tick_mode[1] = 3;
    @(negedge clk);
    p_data[1] = 9'h055; pen[1] = 1'b0; ptyp[1] = 1'b0; dv[1] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!busy[1] && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("b2b_first_accept", 1, 32'(busy[1]), 32'(1));
    p_data[1] = 9'h080;
    wait_done(1);
    @(negedge clk);
    check("b2b_second_accept", 1, 32'(busy[1]), 32'(1));
    dv[1] = 1'b0;
    wait_done(1);

    // request while busy must be ignored
    send(0, 9'h03C, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    p_data[0] = 9'h0FF; dv[0] = 1'b1;
    @(negedge clk);
    dv[0] = 1'b0;
    wait_done(0);
    repeat (60) @(negedge clk);

    // abort during data bit 3 (fifth tick after acceptance), then recover
    send(0, 9'h0C3, 1'b1, 1'b1);
    n = 0;
    k = 0;
    while (n < 5 && k < 200) begin
      @(posedge clk);
      if (tick[0]) n++;
      k++;
    end
    check("abort_reach_bit3", 0, 32'(n), 32'(5));
    async_reset_check();
    send(0, 9'h0B2, 1'b1, 1'b0);
    wait_done(0);

    // tick every cycle on the 5-bit instance
    tick_mode[2] = 1;
    send(2, 9'h016, 1'b0, 1'b0);
    wait_done(2);
    send(2, 9'h009, 1'b1, 1'b1);
    wait_done(2);

    // randomized frames across all instances and tick rates
    for (int r = 0; r < 40; r++) begin
      k = $urandom_range(0, 2);
      tick_mode[k] = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(1, 5));
      send(k, 9'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      wait_done(k);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (10) @(negedge clk);
    check("sb_drain", 0, 32'(g_inst[0].exp_q.size()), 32'(0));
    check("sb_drain", 1, 32'(g_inst[1].exp_q.size()), 32'(0));
    check("sb_drain", 2, 32'(g_inst[2].exp_q.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame_engine.md
# uart_tx_frame_engine

Parametrised UART transmit frame engine. It replaces the fixed 4-way output selector with a complete serializer that accepts a parallel word over a valid/busy handshake and emits a full frame, least-significant data bit first:

- start bit
- data bits
- optional even/odd parity bit
- one or two stop bits

Bit timing comes from an external baud strobe. TX_Out is a registered output and feeds the UART pad directly.

## Interface
Parameters:
- DATA_WIDTH, 8, number of data bits per frame (legal 5..9).
- STOP_BITS, 1, number of stop bits (legal 1 or 2).

Ports:
- CLK  in  1  single system clock; all logic is clocked on its rising edge.
- RST  in  1  asynchronous, active-high reset.
- P_Data  in  DATA_WIDTH  parallel word to transmit.
- Data_Valid  in  1  request; a word is accepted on a CLK edge where Data_Valid=1 and Busy=0.
- PAR_EN  in  1  1 = insert a parity bit; sampled at acceptance.
- PAR_TYP  in  1  0 = even parity, 1 = odd parity; sampled at acceptance.
- Bit_Tick  in  1  baud strobe, one CLK wide, one pulse per bit period.
- TX_Out  out  1  serial line, registered, idles high.
- Busy  out  1  high from acceptance until the frame has completed.
- Frame_Done  out  1  one-cycle pulse on the edge the engine returns to IDLE.

## Operation
- **States:** IDLE, ARMED, START, DATA, PARITY, STOP.
- **Reset (any time, including mid-frame):** state=IDLE, TX_Out=1, Busy=0, Frame_Done=0, and the bit and stop counters are cleared. Reset aborts any partial frame with no glitch low.
- **IDLE:**
  - TX_Out=1, Busy=0.
  - On an edge with Data_Valid=1, latch P_Data, PAR_EN and PAR_TYP, compute parity, set Busy=1 and go to ARMED.
  - Bit_Tick is ignored in IDLE.
- **ARMED:** wait. On the next edge with Bit_Tick=1, set TX_Out<=0 and go to START. A Bit_Tick on the acceptance edge itself does not count.
- **START:** on Bit_Tick, TX_Out<=data[0], bit counter=0, go to DATA.
- **DATA:** on Bit_Tick:
  - If the counter is below DATA_WIDTH-1, increment it and drive TX_Out<=data[counter+1].
  - Otherwise, drive TX_Out<=parity and go to PARITY if PAR_EN=1.
  - Otherwise, drive TX_Out<=1 and go to STOP.
- **PARITY:** on Bit_Tick, TX_Out<=1, go to STOP.
- **STOP:**
  - On each Bit_Tick, count stop bits.
  - When STOP_BITS bit periods have elapsed, go to IDLE with Busy<=0 and Frame_Done<=1 for one cycle. TX_Out remains 1.
- **Parity:** even = XOR of the latched data bits; odd = its inverse. The result is computed on the latched copy, so P_Data may change after acceptance.
- **While Busy=1:** Data_Valid, P_Data, PAR_EN and PAR_TYP are ignored. There is no queueing.
- **Back-to-back frames:** the earliest next acceptance is the edge after Frame_Done. No Data_Valid sampled on the Frame_Done edge is accepted.
- **Counter widths:** the bit counter is $clog2(DATA_WIDTH) bits. The stop counter is 1 bit.

## Timing
- All outputs change only on CLK rising edges; TX_Out, Busy and Frame_Done are flops.
- **Acceptance latency:** Busy is high the cycle after the accepting edge.
- **Start bit:** begins on the first Bit_Tick edge strictly after acceptance. Each bit then holds for exactly one Bit_Tick interval.
- **Frame length:** N = 1 + DATA_WIDTH + PAR_EN + STOP_BITS bit periods. Busy falls on the Bit_Tick edge that ends the last stop bit.
- **Bit_Tick every cycle:** legal. Each bit then lasts one CLK.
- **Bit_Tick and Data_Valid high together in IDLE:** accept only. The start bit waits for the next tick.

## Test plan
1. **Reset values:** assert RST asynchronously mid-cycle → TX_Out=1, Busy=0, Frame_Done=0 immediately. Release RST, hold Data_Valid=0 → line stays 1.
2. **Even-parity frame:** DATA_WIDTH=8, STOP_BITS=1, PAR_EN=1, PAR_TYP=0, P_Data=0xA5, Bit_Tick every 4 CLKs.
   - TX_Out sequence per tick: 0,1,0,1,0,0,1,0,1,0,1.
   - Busy spans 11 tick periods plus the arm wait.
   - Frame_Done pulses once.
3. **Odd parity and no parity:** P_Data=0x0F.
   - PAR_TYP=1 → parity bit 1.
   - PAR_EN=0 → 10-bit frame 0,1,1,1,1,0,0,0,0,1.
4. **Two stop bits with back-to-back frames:** STOP_BITS=2, Data_Valid held high, words 0x55 then 0x80.
   - Two tick periods of 1 between the frames.
   - The second acceptance occurs exactly on the edge after Frame_Done.
   - 0x80 serializes LSB first.
5. **Busy rejection:** change P_Data to 0xFF and pulse Data_Valid mid-frame → the transmitted frame is unchanged and no extra frame follows.
6. **Abort and boundaries:** assert RST during DATA bit 3 → line returns to 1, Busy=0, and the next accepted frame is complete and correct. Also cover Bit_Tick every cycle with DATA_WIDTH=5 → 8-cycle frame with parity disabled.
